// File: rtl/sudoku_board_loader.sv
// Staging board between the handwriting recogniser and the Sudoku solver: collects cells in any
// order, then streams all 81 words in solver order. Optional auto-commit via SUDOKU_AUTO_COMMIT_EN.
module sudoku_board_loader #(
    parameter int unsigned DATA_W     = 11,
    parameter int unsigned STREAM_GAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cell_valid,
    output logic              o_cell_ready,
    input  logic [3:0]        i_cell_row,
    input  logic [3:0]        i_cell_col,
    input  logic [3:0]        i_cell_digit,
    input  logic              i_load_commit,
    output logic              o_reading,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_solver_done,
    output logic              o_busy,
    output logic              o_err
);

    localparam int unsigned       CELLS      = 81;
    localparam logic [DATA_W-1:0] EMPTY_WORD = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [3:0]        GAP_INIT   = 4'(STREAM_GAP);

    typedef enum logic [1:0] {
        StLoad,
        StStream,
        StWait
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_board [CELLS];
    logic [3:0]        r_row;
    logic [3:0]        r_col;
    logic [3:0]        r_gap;
    logic              r_reading;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic              r_err;
    logic              r_cell_ready;

    logic              w_xfer;
    logic              w_legal;
    logic              w_wr;
    logic [6:0]        w_wr_idx;
    logic [6:0]        w_rd_idx;
    logic [DATA_W-1:0] w_wr_word;
    logic              w_commit;

    assign w_xfer    = i_cell_valid && r_cell_ready;
    assign w_legal   = (i_cell_row <= 4'd8) && (i_cell_col <= 4'd8) && (i_cell_digit <= 4'd9);
    assign w_wr      = w_xfer && w_legal;
    assign w_wr_idx  = 7'(i_cell_row) * 7'd9 + 7'(i_cell_col);
    assign w_wr_word = (i_cell_digit == 4'd0) ? EMPTY_WORD
                                              : {{(DATA_W-4){1'b0}}, i_cell_digit};
    // Solver order walks rows fastest within each column.
    assign w_rd_idx  = 7'(r_row) * 7'd9 + 7'(r_col);

`ifdef SUDOKU_AUTO_COMMIT_EN
    logic [CELLS-1:0] r_map;
    logic [CELLS-1:0] w_map_next;
    logic             w_auto;

    assign w_map_next = r_map | (w_wr ? ({{(CELLS-1){1'b0}}, 1'b1} << w_wr_idx) : '0);
    assign w_auto     = w_wr && (&w_map_next) && !(&r_map);
    assign w_commit   = i_load_commit || w_auto;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map <= '0;
        end else if (r_state == StLoad) begin
            r_map <= w_map_next;
        end else if (r_state == StWait && i_solver_done) begin
            r_map <= '0;
        end
    end
`else
    assign w_commit = i_load_commit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StLoad;
            r_row        <= 4'd0;
            r_col        <= 4'd0;
            r_gap        <= 4'd0;
            r_reading    <= 1'b0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_cell_ready <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                r_board[i] <= EMPTY_WORD;
            end
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (w_wr) begin
                        r_board[w_wr_idx] <= w_wr_word;
                    end
                    if (w_xfer && !w_legal) begin
                        r_err <= 1'b1;
                    end
                    if (w_commit) begin
                        r_state      <= StStream;
                        r_cell_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_row        <= 4'd0;
                        r_col        <= 4'd0;
                        r_gap        <= 4'd0;
                    end else begin
                        r_cell_ready <= 1'b1;
                    end
                end
                StStream: begin
                    if (r_gap != 4'd0) begin
                        // Idle slot: data holds the last word.
                        r_reading <= 1'b0;
                        r_gap     <= r_gap - 4'd1;
                    end else if (r_col == 4'd9) begin
                        r_reading <= 1'b0;
                        r_data    <= '0;
                        r_state   <= StWait;
                    end else begin
                        r_reading <= 1'b1;
                        r_data    <= r_board[w_rd_idx];
                        r_gap     <= GAP_INIT;
                        if (r_row == 4'd8) begin
                            r_row <= 4'd0;
                            r_col <= r_col + 4'd1;
                        end else begin
                            r_row <= r_row + 4'd1;
                        end
                    end
                end
                StWait: begin
                    if (i_solver_done) begin
                        r_state      <= StLoad;
                        r_busy       <= 1'b0;
                        r_err        <= 1'b0;
                        r_cell_ready <= 1'b1;
                        r_row        <= 4'd0;
                        r_col        <= 4'd0;
                        r_gap        <= 4'd0;
                        for (int i = 0; i < CELLS; i++) begin
                            r_board[i] <= EMPTY_WORD;
                        end
                    end
                end
                default: begin
                    r_state <= StLoad;
                end
            endcase
        end
    end

    assign o_cell_ready = r_cell_ready;
    assign o_reading    = r_reading;
    assign o_data       = r_data;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule

// File: tb/tb_sudoku_board_loader.sv
// Randomised bench for sudoku_board_loader: one instance with no stream gap, one with a gap of 2,
// both checked against a 9x9 board model. Covers SUDOKU_AUTO_COMMIT_EN when that macro is defined.
module tb_sudoku_board_loader;

    localparam int NCAP = 260;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cell_valid;
    logic [3:0]  cell_row;
    logic [3:0]  cell_col;
    logic [3:0]  cell_digit;
    logic        load_commit;
    logic        solver_done;

    logic        cr0, rd0, bz0, er0;
    logic [10:0] d0;
    logic        cr2, rd2, bz2, er2;
    logic [10:0] d2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          bm [9][9];
    bit          err_exp;

    logic        s_rd0 [NCAP+1];
    logic        s_rd2 [NCAP+1];
    logic [10:0] s_d0  [NCAP+1];
    logic [10:0] s_d2  [NCAP+1];
    logic        s_bz  [NCAP+1];
    logic        s_cr  [NCAP+1];

    always #5 clk = ~clk;

    sudoku_board_loader #(.DATA_W(11), .STREAM_GAP(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cell_valid (cell_valid),
        .o_cell_ready (cr0),
        .i_cell_row   (cell_row),
        .i_cell_col   (cell_col),
        .i_cell_digit (cell_digit),
        .i_load_commit(load_commit),
        .o_reading    (rd0),
        .o_data       (d0),
        .i_solver_done(solver_done),
        .o_busy       (bz0),
        .o_err        (er0)
    );

    sudoku_board_loader #(.DATA_W(11), .STREAM_GAP(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cell_valid (cell_valid),
        .o_cell_ready (cr2),
        .i_cell_row   (cell_row),
        .i_cell_col   (cell_col),
        .i_cell_digit (cell_digit),
        .i_load_commit(load_commit),
        .o_reading    (rd2),
        .o_data       (d2),
        .i_solver_done(solver_done),
        .o_busy       (bz2),
        .o_err        (er2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Word k of a frame sits at row k%9, column k/9 of the board.
    function automatic logic [10:0] exp_word(input int k);
        int r = k % 9;
        int c = k / 9;
        return (bm[r][c] == 0) ? 11'h400 : 11'(bm[r][c]);
    endfunction

    function automatic bit is_legal(input int r, input int c, input int d);
        return (r <= 8) && (c <= 8) && (d <= 9);
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) bm[r][c] = 0;
    endtask

    task automatic apply_cell(input int r, input int c, input int d);
        if (is_legal(r, c, d)) bm[r][c] = d;
        else err_exp = 1'b1;
    endtask

    task automatic send_cell(input int r, input int c, input int d);
        cell_valid = 1'b1;
        cell_row   = 4'(r);
        cell_col   = 4'(c);
        cell_digit = 4'(d);
        @(posedge clk); #1;
        cell_valid = 1'b0;
        apply_cell(r, c, d);
    endtask

    task automatic send_random_cell(input bit allow_bad);
        int r = $urandom_range(0, 8);
        int c = $urandom_range(0, 8);
        int d = $urandom_range(0, 9);
        if (allow_bad && $urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
                0:       r = $urandom_range(9, 15);
                1:       c = $urandom_range(9, 15);
                default: d = $urandom_range(10, 15);
            endcase
        end
        send_cell(r, c, d);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic commit(input bit with_cell, input int r, input int c, input int d);
        load_commit = 1'b1;
        if (with_cell) begin
            cell_valid = 1'b1;
            cell_row   = 4'(r);
            cell_col   = 4'(c);
            cell_digit = 4'(d);
        end
        @(posedge clk); #1;
        load_commit = 1'b0;
        cell_valid  = 1'b0;
        if (with_cell) apply_cell(r, c, d);
    endtask

    // Sample both instances for NCAP cycles after the commit edge; pulse commit+done at cycle inj.
    task automatic capture(input int inj);
        for (int n = 1; n <= NCAP; n++) begin
            @(posedge clk); #1;
            load_commit = 1'b0;
            solver_done = 1'b0;
            s_rd0[n] = rd0;
            s_d0[n]  = d0;
            s_rd2[n] = rd2;
            s_d2[n]  = d2;
            s_bz[n]  = bz0 & bz2;
            s_cr[n]  = cr0 | cr2;
            if (n == inj) begin
                load_commit = 1'b1;
                solver_done = 1'b1;
            end
        end
    endtask

    task automatic eval_frame(input string tag);
        for (int n = 1; n <= NCAP; n++) begin
            logic        e0_rd = (n <= 81);
            logic [10:0] e0_d  = (n <= 81) ? exp_word(n - 1) : 11'h000;
            logic        e2_rd = (n <= 241) && ((n - 1) % 3 == 0);
            logic [10:0] e2_d  = (n <= 243) ? exp_word((n - 1) / 3) : 11'h000;
            check_eq($sformatf("%s_rd0[%0d]", tag, n), 32'(s_rd0[n]), 32'(e0_rd));
            check_eq($sformatf("%s_d0[%0d]", tag, n), 32'(s_d0[n]), 32'(e0_d));
            check_eq($sformatf("%s_rd2[%0d]", tag, n), 32'(s_rd2[n]), 32'(e2_rd));
            check_eq($sformatf("%s_d2[%0d]", tag, n), 32'(s_d2[n]), 32'(e2_d));
        end
        check_eq({tag, "_busy_first"}, 32'(s_bz[1]), 32'd1);
        check_eq({tag, "_busy_wait"}, 32'(s_bz[NCAP]), 32'd1);
        check_eq({tag, "_ready_first"}, 32'(s_cr[1]), 32'd0);
        check_eq({tag, "_ready_wait"}, 32'(s_cr[NCAP]), 32'd0);
        check_eq({tag, "_err0"}, 32'(er0), 32'(err_exp));
        check_eq({tag, "_err2"}, 32'(er2), 32'(err_exp));
    endtask

    task automatic finish_frame(input string tag);
        solver_done = 1'b1;
        @(posedge clk); #1;
        solver_done = 1'b0;
        clear_model();
        err_exp = 1'b0;
        check_eq({tag, "_done_ready0"}, 32'(cr0), 32'd1);
        check_eq({tag, "_done_ready2"}, 32'(cr2), 32'd1);
        check_eq({tag, "_done_busy"}, 32'(bz0 | bz2), 32'd0);
        check_eq({tag, "_done_err"}, 32'(er0 | er2), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cell_valid  = 1'b0;
        cell_row    = '0;
        cell_col    = '0;
        cell_digit  = '0;
        load_commit = 1'b0;
        solver_done = 1'b0;
        err_exp     = 1'b0;
        clear_model();

        #12;
        check_eq("rst_ready", 32'(cr0 | cr2), 32'd0);
        check_eq("rst_reading", 32'(rd0 | rd2), 32'd0);
        check_eq("rst_data", 32'(d0 | d2), 32'd0);
        check_eq("rst_busy", 32'(bz0 | bz2), 32'd0);
        check_eq("rst_err", 32'(er0 | er2), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready_pre_edge", 32'(cr0), 32'd0);
        @(posedge clk); #1;
        check_eq("rel_ready", 32'(cr0 & cr2), 32'd1);

        // Three digits plus an overwrite back to empty.
        send_cell(0, 0, 5);
        send_cell(8, 8, 9);
        send_cell(1, 0, 3);
        send_cell(2, 3, 7);
        send_cell(2, 3, 0);
        check_eq("A_err_pre", 32'(er0), 32'd0);
        commit(1'b0, 0, 0, 0);
        check_eq("A_commit_busy", 32'(bz0), 32'd1);
        check_eq("A_commit_reading", 32'(rd0), 32'd0);
        capture(0);
        eval_frame("A");
        check_eq("A_word0", 32'(s_d0[1]), 32'h005);
        check_eq("A_word1", 32'(s_d0[2]), 32'h003);
        check_eq("A_word29", 32'(s_d0[30]), 32'h400);
        check_eq("A_word80", 32'(s_d0[81]), 32'h009);
        finish_frame("A");

        // Illegal cells are consumed, never stored, and raise err.
        send_cell(9, 0, 1);
        check_eq("B_err_row", 32'(er0 & er2), 32'd1);
        send_cell(0, 0, 12);
        check_eq("B_err_digit", 32'(er0 & er2), 32'd1);
        commit(1'b0, 0, 0, 0);
        capture(0);
        eval_frame("B");
        finish_frame("B");

        for (int f = 0; f < 3; f++) begin
            int nc = $urandom_range(10, 40);
            for (int i = 0; i < nc; i++) send_random_cell(1'b1);
            check_eq($sformatf("R%0d_err_pre", f), 32'(er0), 32'(err_exp));
            commit(1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 9),
                   $urandom_range(0, 10));
            capture($urandom_range(0, 70));
            eval_frame($sformatf("R%0d", f));
            finish_frame($sformatf("R%0d", f));
        end

        // Same-cycle cell and commit, plus stray commit/done while streaming.
        for (int i = 0; i < 8; i++) send_random_cell(1'b0);
        commit(1'b1, 4, 4, 6);
        capture(20);
        eval_frame("C");
        check_eq("C_word40", 32'(s_d0[41]), 32'h006);
        finish_frame("C");

        // Reset while word 40 is on the bus truncates the frame.
        commit(1'b1, 4, 4, 6);
        for (int n = 1; n <= 41; n++) begin
            @(posedge clk); #1;
        end
        check_eq("D_word40_rd", 32'(rd0), 32'd1);
        check_eq("D_word40", 32'(d0), 32'h006);
        #2 rst_n = 1'b0;
        #1;
        check_eq("D_rst_reading", 32'(rd0 | rd2), 32'd0);
        check_eq("D_rst_data", 32'(d0 | d2), 32'd0);
        check_eq("D_rst_busy", 32'(bz0 | bz2), 32'd0);
        check_eq("D_rst_ready", 32'(cr0 | cr2), 32'd0);
        clear_model();
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("D_rel_ready", 32'(cr0 & cr2), 32'd1);

        commit(1'b0, 0, 0, 0);
        capture(0);
        eval_frame("E");
        finish_frame("E");

`ifdef SUDOKU_AUTO_COMMIT_EN
        begin
            int order [81];
            for (int i = 0; i < 81; i++) order[i] = i;
            for (int i = 80; i > 0; i--) begin
                int j = $urandom_range(0, i);
                int t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
            for (int i = 0; i < 81; i++) begin
                int r = order[i] / 9;
                int c = order[i] % 9;
                if (i == 80) check_eq("F_busy_pre", 32'(bz0), 32'd0);
                send_cell(r, c, (r + c) % 9 + 1);
            end
            check_eq("F_auto_busy", 32'(bz0 & bz2), 32'd1);
            check_eq("F_auto_reading", 32'(rd0), 32'd0);
            capture(0);
            eval_frame("F");
            check_eq("F_word10", 32'(s_d0[11]), 32'h003);
            finish_frame("F");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sudoku_board_loader.md
Name: sudoku_board_loader

Overview:
- Upstream stage of the Sudoku solver.
- Collects recognised digits from the handwriting recogniser. Cells arrive in any order, addressed by row and column.
- Holds them in a 9x9 staging board, then streams all 81 cells into the solver's reading/data interface in the solver's index order.
- Waits for the solver's done pulse, clears the staging board and accepts the next puzzle.

Parameters:
- DATA_W, 11, width of a solver cell word; bit DATA_W-1 = empty flag, bits [DATA_W-2:0] = digit value, zero-extended binary.
- STREAM_GAP, 0, number of idle cycles (reading low) inserted between consecutive streamed words; range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cell_valid  input  1  recogniser presents a cell this cycle.
- cell_ready  output  1  loader accepts a cell; a transfer occurs when cell_valid && cell_ready.
- cell_row  input  4  row 0..8.
- cell_col  input  4  column 0..8.
- cell_digit  input  4  0 = empty, 1..9 = digit.
- load_commit  input  1  single-cycle pulse: board complete, start streaming.
- reading  output  1  to solver: data is a valid cell word this cycle.
- data  output  DATA_W  to solver: cell word.
- solver_done  input  1  from solver: puzzle processed.
- busy  output  1  high in STREAM and WAIT.
- err  output  1  sticky: an illegal cell was rejected; cleared by reset or on entry to LOAD from WAIT.

Behaviour:
- Reset (async, rst_n low):
  - state = LOAD.
  - All 81 staging entries = empty word: bit 10 set, rest 0 (11'h400).
  - reading = 0, data = 0, busy = 0, err = 0.
  - Counters = 0.
  - cell_ready = 0 while rst_n is low; 1 from the first clk edge after release.
- Empty and digit encoding:
  - Empty word = {1'b1, 10'd0}.
  - Digit d = {1'b0, 6'd0, d[3:0]}.
- State LOAD:
  - cell_ready = 1.
  - Legal transfer (row <= 8, col <= 8, digit <= 9): writes staging[row][col] at the clock edge. Digit 0 writes the empty word. A later write to the same cell overwrites the earlier one.
  - Illegal transfer: consumed but not stored; err set next cycle.
  - load_commit high: go to STREAM at the next edge.
  - cell_valid and load_commit in the same cycle: the cell is stored and is included in the stream.
- State STREAM:
  - cell_ready = 0, busy = 1.
  - Word counter k runs 0..80, with row = k % 9 and col = k / 9 (row index varies fastest).
  - reading and data are registered outputs. The first word appears on the cycle after the commit edge.
  - With STREAM_GAP = 0: reading is high for exactly 81 consecutive cycles.
  - With STREAM_GAP = G: each word is followed by G cycles of reading = 0, during which data holds its last value.
  - After word 80: reading = 0, data = 0, go to WAIT.
- State WAIT:
  - busy = 1, cell_ready = 0.
  - When solver_done is sampled high: on that edge all staging entries are cleared to empty, err is cleared, and the state returns to LOAD.
  - solver_done during LOAD or STREAM is ignored.
  - load_commit outside LOAD is ignored.
- Reset mid-stream: reading drops to 0 asynchronously, board cleared, state LOAD; the solver sees a truncated frame.
- Staging storage is a flat 81-entry register array indexed row*9+col.
- Output data is driven only from registers; there is no combinational path from the cell_* inputs to data.

Optional Feature:
- Macro SUDOKU_AUTO_COMMIT_EN.
- When defined:
  - An 81-bit written-map is kept; a bit is set on each legal write.
  - When the last unset bit becomes set, the loader behaves as if load_commit pulsed that cycle, so STREAM starts on the next edge.
  - The map clears together with the board.
  - An explicit load_commit still works.
- When undefined: no map is kept, and only load_commit starts streaming.

Test Plan:
- Reset, write (r0,c0)=5, (r8,c8)=9 and (r1,c0)=3, pulse load_commit, gap 0 -> 81 consecutive reading cycles; word0 = 11'h005, word1 = 11'h003, word80 = 11'h009, all others 11'h400; busy high; cell_ready low.
- Write (r2,c3)=7, then (r2,c3)=0, then commit -> word k=29 = 11'h400.
- Illegal cells row=9, then digit=12 -> err = 1, streamed board all empty; after solver_done, err = 0 and cell_ready = 1.
- STREAM_GAP=2, commit an empty board -> reading pattern 1,0,0 repeated 81 times; total 243 cycles until WAIT.
- cell_valid (r4,c4)=6 in the same cycle as load_commit -> word k=40 = 11'h006. load_commit and solver_done pulsed during STREAM -> no effect. rst_n pulled low at word 40 -> reading 0 immediately, next frame streams all empty.
- SUDOKU_AUTO_COMMIT_EN defined, write all 81 cells with digit (row+col)%9+1, no load_commit -> reading rises 1 cycle after the 81st write edge; word k carries (k%9 + k/9)%9+1.
